// File: rtl/uc_multiplier8bits.sv
// -----------------------------------------------------------------------------
// uc_multiplier8bits
// Control unit for the FD_multiplier8bits datapath. It walks the datapath
// through one multiply by issuing the register load strobes and the ROM /
// adder mux selects in a fixed order, then waits for the datapath PRONTO
// flag. The system sees a START / BUSY / DONE handshake plus a sticky ERROR
// flag raised when PRONTO does not arrive within TIMEOUT cycles.
//
// Parameters
//   SETUP_CYC : cycles a select is held with its strobe low before the strobe
//               cycle of each phased state (0..7)
//   TIMEOUT   : maximum cycles spent waiting for PRONTO (1..255)
//
// Ports
//   CLK            in   clock, rising edge
//   RESET          in   synchronous active-low reset
//   START          in   multiply request, sampled only in IDLE
//   PRONTO         in   datapath result-valid flag
//   LD_XY .. LD_RES out one-cycle register load strobes
//   SELROM         out  ROM address select (2 bits)
//   SELSOMA        out  adder operand select (2 bits)
//   BUSY           out  high whenever the unit is not idle
//   DONE           out  one-cycle completion pulse
//   ERROR          out  sticky PRONTO-timeout flag
// -----------------------------------------------------------------------------
module uc_multiplier8bits #(
   parameter int SETUP_CYC = 1,
   parameter int TIMEOUT   = 8
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic       PRONTO,
   output logic       LD_XY,
   output logic       LD_DE0,
   output logic       LD_A,
   output logic       LD_B,
   output logic       LD_DE1,
   output logic       LD_AB,
   output logic       LD_DE_ABshift,
   output logic       LD_RES,
   output logic [1:0] SELROM,
   output logic [1:0] SELSOMA,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERROR
);

   localparam logic [2:0] C_SETUP   = 3'(SETUP_CYC);
   localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      IDLE        = 4'd0,
      LOAD_XY     = 4'd1,
      LOAD_DE0    = 4'd2,
      ROM_A       = 4'd3,
      ROM_B       = 4'd4,
      ROM_DE1     = 4'd5,
      SUM_AB      = 4'd6,
      SHIFT       = 4'd7,
      RES         = 4'd8,
      WAIT_PRONTO = 4'd9,
      DONE_ST     = 4'd10
   } state_t;

   // Strobe vector order: XY, DE0, A, B, DE1, AB, DE_ABshift, RES (msb first)
   typedef struct packed {
      logic [7:0] ld;
      logic [1:0] selrom;
      logic [1:0] selsoma;
      logic       busy;
      logic       done;
   } out_t;

   state_t     r_state;
   logic [2:0] r_setup_cnt;
   logic [7:0] r_to_cnt;
   logic       r_error;
   out_t       r_out;

   state_t     w_state_nxt;
   logic [2:0] w_setup_nxt;
   logic [7:0] w_to_nxt;
   logic       w_error_nxt;

   // Successor of a phased state; the last one hands over to the PRONTO wait.
   function automatic state_t f_next_phase(input state_t st);
      state_t nx;
      case (st)
         ROM_A:   nx = ROM_B;
         ROM_B:   nx = ROM_DE1;
         ROM_DE1: nx = SUM_AB;
         SUM_AB:  nx = SHIFT;
         SHIFT:   nx = RES;
         RES:     nx = WAIT_PRONTO;
         default: nx = IDLE;
      endcase
      return nx;
   endfunction

   // Moore output decode. The strobe of a phased state fires only when the
   // setup counter has run down to zero, i.e. in the last cycle of the state.
   function automatic out_t f_decode(input state_t st, input logic [2:0] cnt);
      out_t o;
      logic last;
      o      = '0;
      last   = (cnt == 3'd0);
      o.busy = (st != IDLE);
      case (st)
         IDLE:        o.busy       = 1'b0;
         LOAD_XY:     o.ld[7]      = 1'b1;
         LOAD_DE0:    o.ld[6]      = 1'b1;
         ROM_A:       begin o.selrom  = 2'd1; o.ld[5] = last; end
         ROM_B:       begin o.selrom  = 2'd2; o.ld[4] = last; end
         ROM_DE1:     begin o.selrom  = 2'd3; o.ld[3] = last; end
         SUM_AB:      begin o.selsoma = 2'd1; o.ld[2] = last; end
         SHIFT:       begin o.selsoma = 2'd2; o.ld[1] = last; end
         RES:         begin o.selsoma = 2'd3; o.ld[0] = last; end
         WAIT_PRONTO: o.done       = 1'b0;
         DONE_ST:     o.done       = 1'b1;
         default:     o            = '0;
      endcase
      return o;
   endfunction

   // Next-state, counter and error-flag logic.
   always_comb begin
      w_state_nxt = r_state;
      w_setup_nxt = r_setup_cnt;
      w_to_nxt    = r_to_cnt;
      w_error_nxt = r_error;
      case (r_state)
         IDLE: begin
            if (START) begin
               w_state_nxt = LOAD_XY;
               w_error_nxt = 1'b0;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         LOAD_XY: w_state_nxt = LOAD_DE0;
         LOAD_DE0: begin
            w_state_nxt = ROM_A;
            w_setup_nxt = C_SETUP;
         end
         ROM_A, ROM_B, ROM_DE1, SUM_AB, SHIFT, RES: begin
            if (r_setup_cnt == 3'd0) begin
               // Reload on every phased-state entry; harmless when leaving to WAIT.
               w_state_nxt = f_next_phase(r_state);
               w_setup_nxt = C_SETUP;
               w_to_nxt    = 8'd0;
            end else begin
               w_setup_nxt = r_setup_cnt - 3'd1;
            end
         end
         WAIT_PRONTO: begin
            if (PRONTO) begin
               w_state_nxt = DONE_ST;
               w_to_nxt    = 8'd0;
            end else if (r_to_cnt == C_TO_LAST) begin
               // TIMEOUT consecutive cycles without PRONTO: abandon the run.
               w_state_nxt = IDLE;
               w_error_nxt = 1'b1;
               w_to_nxt    = 8'd0;
            end else begin
               w_to_nxt    = r_to_cnt + 8'd1;
            end
         end
         DONE_ST: w_state_nxt = IDLE;
         default: begin
            w_state_nxt = IDLE;
            w_setup_nxt = 3'd0;
            w_to_nxt    = 8'd0;
         end
      endcase
   end

   // State, counters, error flag and registered outputs. Outputs are decoded
   // from the next state so they line up with the state they describe.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_state     <= IDLE;
         r_setup_cnt <= 3'd0;
         r_to_cnt    <= 8'd0;
         r_error     <= 1'b0;
         r_out       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_setup_cnt <= w_setup_nxt;
         r_to_cnt    <= w_to_nxt;
         r_error     <= w_error_nxt;
         r_out       <= f_decode(w_state_nxt, w_setup_nxt);
      end
   end

   assign LD_XY         = r_out.ld[7];
   assign LD_DE0        = r_out.ld[6];
   assign LD_A          = r_out.ld[5];
   assign LD_B          = r_out.ld[4];
   assign LD_DE1        = r_out.ld[3];
   assign LD_AB         = r_out.ld[2];
   assign LD_DE_ABshift = r_out.ld[1];
   assign LD_RES        = r_out.ld[0];
   assign SELROM        = r_out.selrom;
   assign SELSOMA       = r_out.selsoma;
   assign BUSY          = r_out.busy;
   assign DONE          = r_out.done;
   assign ERROR         = r_error;

endmodule
